mac_host_ctrl: RTL and testbench

MAC_HOST_CTRL -- requirements
Module: mac_host_ctrl

---
 rtl/mac_host_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mac_host_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mac_host_ctrl.sv
// Host-side controller for an external multiply-accumulate unit: streams operand
// bursts into the MAC, reports the burst sum, and preloads the accumulator upper byte.
module mac_host_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  input  logic        op_last,
  input  logic        pre_valid,
  output logic        pre_ready,
  input  logic [7:0]  pre_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [7:0]  res_count,
  output logic        mac_acc_en,
  output logic        mac_load_ext_high,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  input  logic [7:0]  mac_out_low,
  inout  wire  [7:0]  mac_io_high,
  output logic        mac_io_drive
);

  typedef enum logic [3:0] {
    IDLE, SNAP, RUN, DRAIN, READ, RESP, TOFF, PDRV, TON
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] res_data_q, res_data_d;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  mac_a_q, mac_a_d;
  logic [7:0]  mac_b_q, mac_b_d;
  logic        acc_en_q, acc_en_d;
  logic        load_q, load_d;
  logic        io_oe_q, io_oe_d;
  logic        drive_q, drive_d;
  logic        op_ready_q, op_ready_d;
  logic        pre_ready_q, pre_ready_d;
  logic [7:0]  pre_q, pre_d;

  logic [15:0] acc_rd;
  logic        op_xfer;

  assign acc_rd  = {mac_io_high, mac_out_low};
  assign op_xfer = op_valid & op_ready_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    acc_en_d    = 1'b0;
    pre_d       = pre_q;

    unique case (state_q)
      IDLE: begin
        // pre_ready_q gates acceptance so nothing is taken on the first cycle out of reset
        if (pre_ready_q) begin
          if (pre_valid) begin
            pre_d   = pre_data;
            state_d = TOFF;
          end else if (op_valid) begin
            state_d = SNAP;
          end
        end
      end
      SNAP: begin
        base_d  = acc_rd;
        state_d = RUN;
      end
      RUN: begin
        if (op_xfer) begin
          mac_a_d  = op_a;
          mac_b_d  = op_b;
          acc_en_d = 1'b1;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
          if (op_last) state_d = DRAIN;
        end
      end
      DRAIN: state_d = READ;
      READ: begin
        res_data_d  = acc_rd - base_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          count_d     = '0;
          state_d     = IDLE;
        end
      end
      TOFF:    state_d = PDRV;
      PDRV:    state_d = TON;
      TON:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they align with the state they belong to
    op_ready_d  = (state_d == RUN);
    pre_ready_d = (state_d == IDLE);
    load_d      = (state_d == PDRV);
    io_oe_d     = (state_d == PDRV);
    drive_d     = !((state_d == TOFF) || (state_d == PDRV) || (state_d == TON));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      acc_en_q    <= 1'b0;
      load_q      <= 1'b0;
      io_oe_q     <= 1'b0;
      drive_q     <= 1'b1;
      op_ready_q  <= 1'b0;
      pre_ready_q <= 1'b0;
      pre_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      acc_en_q    <= acc_en_d;
      load_q      <= load_d;
      io_oe_q     <= io_oe_d;
      drive_q     <= drive_d;
      op_ready_q  <= op_ready_d;
      pre_ready_q <= pre_ready_d;
      pre_q       <= pre_d;
    end
  end

  assign mac_io_high       = io_oe_q ? pre_q : 8'bzzzz_zzzz;
  assign op_ready          = op_ready_q;
  assign pre_ready         = pre_ready_q;
  assign res_valid         = res_valid_q;
  assign res_data          = res_data_q;
  assign res_count         = count_q;
  assign mac_acc_en        = acc_en_q;
  assign mac_load_ext_high = load_q;
  assign mac_a             = mac_a_q;
  assign mac_b             = mac_b_q;
  assign mac_io_drive      = drive_q;

endmodule

// File: tb/tb_mac_host_ctrl.sv
// Directed bench for mac_host_ctrl with a behavioural MAC attached to the shared bus.
module tb_mac_host_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0, op_last = 1'b0;
  logic [7:0]  op_a = '0, op_b = '0;
  logic        pre_valid = 1'b0;
  logic [7:0]  pre_data = '0;
  logic        res_ready = 1'b0;
  logic        op_ready, pre_ready, res_valid;
  logic [15:0] res_data;
  logic [7:0]  res_count;
  logic        mac_acc_en, mac_load_ext_high, mac_io_drive;
  logic [7:0]  mac_a, mac_b, mac_out_low;
  wire  [7:0]  mac_io_high;

  int unsigned n_chk = 0, n_pass = 0, excl_err = 0;

  logic [15:0] acc_q = '0;
  logic        acc_set = 1'b0;
  logic [15:0] acc_set_val = '0;

  always #5 clk = ~clk;

  mac_host_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_last(op_last),
    .pre_valid(pre_valid), .pre_ready(pre_ready), .pre_data(pre_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_count(res_count),
    .mac_acc_en(mac_acc_en), .mac_load_ext_high(mac_load_ext_high),
    .mac_a(mac_a), .mac_b(mac_b), .mac_out_low(mac_out_low),
    .mac_io_high(mac_io_high), .mac_io_drive(mac_io_drive)
  );

  // Behavioural MAC: independent of the host reset
  assign mac_out_low = acc_q[7:0];
  assign mac_io_high = mac_io_drive ? acc_q[15:8] : 8'bzzzz_zzzz;

  always @(posedge clk) begin
    logic [15:0] n;
    n = acc_q;
    if (acc_set) n = acc_set_val;
    else begin
      if (mac_acc_en) n = n + mac_a * mac_b;
      if (mac_load_ext_high) n[15:8] = mac_io_high;
    end
    acc_q <= n;
  end

  always @(negedge clk) if (mac_acc_en && mac_load_ext_high) excl_err++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_xfer(input logic [7:0] a, input logic [7:0] b, input logic last);
    bit done = 0;
    op_valid = 1'b1; op_a = a; op_b = b; op_last = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (op_ready) done = 1;
      tick();
    end
    if (!done) chk("op_handshake", 0, 1);
  endtask

  task automatic expect_result(input logic [15:0] exp_d, input logic [7:0] exp_c,
                               input int hold);
    op_valid = 1'b0; op_last = 1'b0;
    chk("lat_drain", res_valid, 0);
    tick();
    chk("lat_read", res_valid, 0);
    tick();
    chk("lat_resp", res_valid, 1);
    chk("res_data", res_data, exp_d);
    chk("res_count", res_count, exp_c);
    if (hold > 0) begin
      op_valid = 1'b1; op_a = 8'h11; op_b = 8'h22; op_last = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, exp_d);
        chk("hold_count", res_count, exp_c);
        chk("hold_op_ready", op_ready, 0);
        chk("hold_pre_ready", pre_ready, 0);
      end
      op_valid = 1'b0; op_last = 1'b0;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_clr", res_valid, 0);
  endtask

  // Drive sequence across TOFF/PDRV/TON/IDLE; also_op keeps op_valid high throughout
  task automatic preload(input logic [7:0] d, input logic also_op);
    bit done = 0;
    pre_valid = 1'b1; pre_data = d;
    if (also_op) op_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (pre_ready) begin
        chk("drv_idle", mac_io_drive, 1);
        done = 1;
      end
      tick();
    end
    if (!done) chk("pre_handshake", 0, 1);
    pre_valid = 1'b0;
    chk("drv_toff", mac_io_drive, 0);
    chk("toff_op_ready", op_ready, 0);
    tick();
    chk("drv_pdrv", mac_io_drive, 0);
    chk("load_pdrv", mac_load_ext_high, 1);
    chk("bus_pdrv", mac_io_high, d);
    tick();
    chk("drv_ton", mac_io_drive, 0);
    chk("load_ton", mac_load_ext_high, 0);
    tick();
    chk("drv_back", mac_io_drive, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_op_ready", op_ready, 0);
    chk("rst_pre_ready", pre_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_acc_en", mac_acc_en, 0);
    chk("rst_drive", mac_io_drive, 1);
    @(negedge clk); rst_n = 1'b1;
    tick();

    op_xfer(3, 4, 0); op_xfer(2, 5, 0); op_xfer(100, 2, 1);
    expect_result(16'h00DE, 8'd3, 0);
    chk("acc_burst1", acc_q, 16'h00DE);

    preload(8'hAA, 0);
    chk("acc_preload", acc_q, 16'hAADE);
    op_xfer(1, 1, 1);
    expect_result(16'h0001, 8'd1, 0);
    chk("acc_after11", acc_q, 16'hAADF);

    acc_set_val = 16'hFFDE; acc_set = 1'b1;
    tick();
    acc_set = 1'b0;
    op_xfer(255, 255, 1);
    expect_result(16'hFE01, 8'd1, 3);
    chk("acc_wrap", acc_q, 16'hFDDF);

    preload(8'h12, 1);
    op_xfer(2, 3, 1);
    expect_result(16'h0006, 8'd1, 0);

    for (int i = 0; i < 255; i++) op_xfer(0, 0, 0);
    op_xfer(0, 0, 1);
    expect_result(16'h0000, 8'd255, 0);

    op_xfer(7, 7, 0); op_xfer(8, 8, 0);
    op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_op_ready", op_ready, 0);
    chk("arst_acc_en", mac_acc_en, 0);
    chk("arst_mac_a", mac_a, 0);
    chk("arst_drive", mac_io_drive, 1);
    chk("arst_count", res_count, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    tick(); tick(); tick();
    chk("arst_no_result", res_valid, 0);
    op_xfer(5, 5, 1);
    expect_result(16'h0019, 8'd1, 0);

    chk("acc_load_exclusive", excl_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
